carrier_rom_sequencer: RTL and testbench
========================================

Name: carrier_rom_sequencer

Overview:
Time-multiplexes one shared carrier sample ROM across the 15 vocoder carrier bands. The ROM holds all bands concatenated, band-major. On each 44.1 kHz enable it issues 15 back-to-back reads (bands 0..14) at the current sample index and captures each returned word into a per-band output register. It then advances the index with wrap-around. Downstream it presents the same carrier_bands / valid_bus interface the per-band playback bank exposes, so the modulator side is unchanged.

Parameters:
MEM_DEPTH, 4036, samples per band
NUM_BANDS, 15, carrier bands sequenced per frame (fixed ordering 0..NUM_BANDS-1)
ROM_LATENCY, 2, cycles from rom_en/rom_addr to valid rom_data (1..4)
ADDR_WIDTH, $clog2(NUM_BANDS*MEM_DEPTH), ROM address width
IDX_WIDTH, $clog2(MEM_DEPTH), sample index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable_44k  in  1  single-cycle frame strobe
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_WIDTH  band*MEM_DEPTH + sample_idx
rom_data  in  16 signed  ROM read data, valid ROM_LATENCY cycles after rom_en
carrier_bands  out  16 signed x NUM_BANDS  latest captured sample per band
valid_bus  out  NUM_BANDS  bit i pulses 1 cycle when carrier_bands[i] updates
frame_valid  out  1  1-cycle pulse: all bands of the frame captured
busy  out  1  high from frame start until return to IDLE
overrun  out  1  sticky: enable_44k arrived while busy
sample_idx  out  IDX_WIDTH  index used by the next frame

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0. State IDLE, tag pipeline cleared.
- Reset mid-frame discards in-flight reads; no capture or valid pulse occurs after reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE when enable_44k=1. Call this cycle T.
- ISSUE runs cycles T+1..T+NUM_BANDS with rom_en=1, one band per cycle, band k at T+1+k.
- rom_addr is computed from a running base (base += MEM_DEPTH per slot). No multiplier.
- A tag shift register (valid + band number, depth ROM_LATENCY) tracks each read.
- Band k data is sampled at T+1+k+ROM_LATENCY.
- carrier_bands[k] and valid_bus[k] become visible at T+2+k+ROM_LATENCY.
- ISSUE -> DRAIN after the last slot. DRAIN holds until the capture count reaches NUM_BANDS.
- DRAIN -> DONE. DONE has frame_valid=1 at cycle T+NUM_BANDS+2+ROM_LATENCY.
- In DONE, sample_idx increments, wrapping MEM_DEPTH-1 -> 0. DONE -> IDLE.
- busy=1 in every state except IDLE.
- Frame length is NUM_BANDS+3+ROM_LATENCY cycles. The integration guarantees this is less than the enable_44k period.
- enable_44k while busy: strobe ignored, no extra frame queued, overrun set to 1. overrun clears only on rst.
- enable_44k in the DONE cycle counts as busy and sets overrun.
- rom_en=0 and rom_addr holds its last value outside ISSUE.
- carrier_bands hold their values between frames.

Optional Feature:
Macro CARRIER_MUTE_EN.
- Defined: adds input mute_mask (NUM_BANDS bits), sampled in cycle T.
- For a muted band, the issue slot is still consumed (timing identical) but rom_en=0 in that slot.
- The captured value for a muted band is forced to 0, and its valid_bus bit still pulses at the normal cycle.
- Undefined: port absent and every band is read every frame.

Test Plan:
Common bench setup: ROM model with ROM_LATENCY=2, MEM_DEPTH=4, word = band*256+idx.
1. Single frame after reset: enable_44k at T.
   - rom_en high T+1..T+15; addresses 0,4,8,..,56.
   - carrier_bands[k]=k*256 appears at T+4+k; frame_valid at T+19.
   - sample_idx 0->1 visible at T+20.
2. Wrap: run 5 frames.
   - The fifth frame reads idx 0 again (addresses 0,4,..).
   - carrier_bands[3] sequence 768,769,770,771,768; sample_idx returns to 1 after the fifth frame.
3. Overrun: second enable_44k at T+10.
   - Ignored, with exactly one frame_valid.
   - overrun=1 from T+11 and stays 1 through later clean frames until rst.
4. Reset mid-frame: rst at T+8.
   - All outputs 0 next cycle; no valid_bus or frame_valid pulses afterwards.
   - Next enable starts at address 0, idx 0.
5. CARRIER_MUTE_EN with mute_mask=15'h0005.
   - No rom_en in slots for bands 0 and 2; carrier_bands[0]=carrier_bands[2]=0.
   - valid_bus[0] still pulses at T+4; other bands read normally; frame_valid still at T+19.
6. Back-to-back legal frames: enable every 40 cycles for 8 frames.
   - Exactly 8 frame_valid pulses, overrun stays 0, sample_idx ends at 0.

Source files
------------

// File: rtl/carrier_rom_sequencer.sv
// Shares one band-major carrier sample ROM across NUM_BANDS bands, one read per band per frame.
// Optional macro CARRIER_MUTE_EN adds mute_mask: muted bands skip the ROM read and capture 0.
module carrier_rom_sequencer #(
  parameter int MEM_DEPTH   = 4036,
  parameter int NUM_BANDS   = 15,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_WIDTH  = $clog2(NUM_BANDS*MEM_DEPTH),
  parameter int IDX_WIDTH   = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_44k,
`ifdef CARRIER_MUTE_EN
  input  logic [NUM_BANDS-1:0]  mute_mask,
`endif
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic signed [15:0]    rom_data,
  output logic signed [15:0]    carrier_bands [NUM_BANDS],
  output logic [NUM_BANDS-1:0]  valid_bus,
  output logic                  frame_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic [IDX_WIDTH-1:0]  sample_idx
);

  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int CNT_W  = $clog2(NUM_BANDS + 1);
  localparam logic [BAND_W-1:0]     LAST_BAND   = BAND_W'(NUM_BANDS - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT    = CNT_W'(NUM_BANDS);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX    = IDX_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BAND_STRIDE = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [BAND_W-1:0]       band_r, band_s;
  logic [NUM_BANDS-1:0]    mute_r, mute_s, mute_in_s;
  logic                    rom_en_s;
  logic [ADDR_WIDTH-1:0]   rom_addr_s;
  logic                    start_s;
  logic [CNT_W-1:0]        cap_cnt_r;
  logic                    tag_vld_r  [ROM_LATENCY];
  logic                    tag_mute_r [ROM_LATENCY];
  logic [BAND_W-1:0]       tag_band_r [ROM_LATENCY];
  logic                    head_vld_s, head_mute_s;
  logic [BAND_W-1:0]       head_band_s;

`ifdef CARRIER_MUTE_EN
  assign mute_in_s = mute_mask;
`else
  assign mute_in_s = {NUM_BANDS{1'b0}};
`endif

  // The oldest tag lines up with the ROM word returned for that slot.
  assign head_vld_s  = tag_vld_r[ROM_LATENCY-1];
  assign head_mute_s = tag_mute_r[ROM_LATENCY-1];
  assign head_band_s = tag_band_r[ROM_LATENCY-1];

  // Next-state and next issue-port values; rom_addr walks a running base instead of band*MEM_DEPTH.
  always_comb begin
    state_s    = state_r;
    band_s     = band_r;
    mute_s     = mute_r;
    rom_en_s   = 1'b0;
    rom_addr_s = rom_addr;
    start_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_44k) begin
          state_s    = ISSUE;
          start_s    = 1'b1;
          band_s     = {BAND_W{1'b0}};
          mute_s     = mute_in_s;
          rom_en_s   = ~mute_in_s[0];
          rom_addr_s = ADDR_WIDTH'(sample_idx);
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (band_r == LAST_BAND) begin
          state_s = DRAIN;
        end else begin
          band_s     = band_r + BAND_W'(1);
          rom_en_s   = ~mute_r[band_s];
          rom_addr_s = rom_addr + BAND_STRIDE;
        end
      end
      DRAIN: begin
        if (cap_cnt_r == FULL_CNT) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control registers: FSM state, issue port, status flags and the sample index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      band_r      <= {BAND_W{1'b0}};
      mute_r      <= {NUM_BANDS{1'b0}};
      rom_en      <= 1'b0;
      rom_addr    <= {ADDR_WIDTH{1'b0}};
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      sample_idx  <= {IDX_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      band_r      <= band_s;
      mute_r      <= mute_s;
      rom_en      <= rom_en_s;
      rom_addr    <= rom_addr_s;
      busy        <= (state_s != IDLE);
      frame_valid <= (state_s == DONE);
      if (enable_44k && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      if (state_r == DONE) begin
        sample_idx <= (sample_idx == LAST_IDX) ? {IDX_WIDTH{1'b0}} : sample_idx + IDX_WIDTH'(1);
      end
    end
  end

  // Tag pipeline and per-band capture of returned ROM words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_vld_r[i]  <= 1'b0;
        tag_mute_r[i] <= 1'b0;
        tag_band_r[i] <= {BAND_W{1'b0}};
      end
      for (int b = 0; b < NUM_BANDS; b++) begin
        carrier_bands[b] <= 16'sd0;
      end
      valid_bus <= {NUM_BANDS{1'b0}};
      cap_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tag_vld_r[0]  <= (state_r == ISSUE);
      tag_mute_r[0] <= mute_r[band_r];
      tag_band_r[0] <= band_r;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_vld_r[i]  <= tag_vld_r[i-1];
        tag_mute_r[i] <= tag_mute_r[i-1];
        tag_band_r[i] <= tag_band_r[i-1];
      end
      valid_bus <= {NUM_BANDS{1'b0}};
      if (start_s) begin
        cap_cnt_r <= {CNT_W{1'b0}};
      end else if (head_vld_s) begin
        cap_cnt_r <= cap_cnt_r + CNT_W'(1);
      end
      if (head_vld_s) begin
        carrier_bands[head_band_s] <= head_mute_s ? 16'sd0 : rom_data;
        valid_bus[head_band_s]     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_carrier_rom_sequencer.sv
// Randomized bench for carrier_rom_sequencer against a frame-timeline reference model.
// Covers the CARRIER_MUTE_EN variant when that macro is defined.
module tb_carrier_rom_sequencer;

  localparam int MD = 4;
  localparam int NB = 15;
  localparam int RL = 2;
  localparam int AW = $clog2(NB*MD);
  localparam int IW = $clog2(MD);
  localparam int FRAME_LEN = NB + 3 + RL;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable_44k;
  logic [NB-1:0]         mute_mask;
  logic                  rom_en;
  logic [AW-1:0]         rom_addr;
  logic signed [15:0]    rom_data;
  logic signed [15:0]    rom_q1;
  logic signed [15:0]    carrier_bands [NB];
  logic [NB-1:0]         valid_bus;
  logic                  frame_valid;
  logic                  busy;
  logic                  overrun;
  logic [IW-1:0]         sample_idx;

  int n_checks = 0;
  int n_errors = 0;
  int fv_seen  = 0;

  // Reference model state: values visible in the current cycle.
  int                 n_cyc   = 0;
  int                 t_start = -1;
  int                 m_idx   = 0;
  int                 f_idx   = 0;
  int                 m_addr  = 0;
  logic               m_ovr   = 1'b0;
  logic [NB-1:0]      f_mute  = '0;
  logic signed [15:0] m_bands [NB];
  bit                 chk_on  = 1'b0;

  always #5 clk = ~clk;

  carrier_rom_sequencer #(
    .MEM_DEPTH   (MD),
    .NUM_BANDS   (NB),
    .ROM_LATENCY (RL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_44k    (enable_44k),
`ifdef CARRIER_MUTE_EN
    .mute_mask     (mute_mask),
`endif
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .carrier_bands (carrier_bands),
    .valid_bus     (valid_bus),
    .frame_valid   (frame_valid),
    .busy          (busy),
    .overrun       (overrun),
    .sample_idx    (sample_idx)
  );

  // Two-stage ROM holding word = band*256 + idx; junk when not enabled.
  always @(posedge clk) begin
    rom_q1   <= rom_en ? 16'((int'(rom_addr) / MD) * 256 + (int'(rom_addr) % MD)) : 16'hBEEF;
    rom_data <= rom_q1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n_cyc);
    end
  endtask

  task automatic model_check(input logic en, input logic r, input logic [NB-1:0] mm);
    int d;
    int k;
    logic exp_en, exp_fv, exp_busy, issuing;
    logic [NB-1:0] exp_vb;
    exp_en = 1'b0; exp_fv = 1'b0; exp_busy = 1'b0; issuing = 1'b0; exp_vb = '0;
    if (t_start >= 0) begin
      d = n_cyc - t_start;
      if (d >= 1 && d <= NB) begin
        issuing = 1'b1;
        m_addr  = (d - 1) * MD + f_idx;
        exp_en  = !f_mute[d-1];
      end
      if (d >= RL + 2 && d <= RL + 1 + NB) begin
        k = d - RL - 2;
        m_bands[k] = f_mute[k] ? 16'sd0 : 16'(k * 256 + f_idx);
        exp_vb[k]  = 1'b1;
      end
      exp_fv   = (d == NB + 2 + RL);
      exp_busy = (d >= 1 && d <= NB + 2 + RL);
      if (d == FRAME_LEN) begin
        m_idx   = (m_idx + 1) % MD;
        t_start = -1;
      end
    end
    if (chk_on) begin
      check("rom_en", rom_en, exp_en);
      if (exp_en || !issuing) check("rom_addr", rom_addr, m_addr);
      check("valid_bus", valid_bus, exp_vb);
      check("frame_valid", frame_valid, exp_fv);
      check("busy", busy, exp_busy);
      check("overrun", overrun, m_ovr);
      check("sample_idx", sample_idx, m_idx);
      for (int b = 0; b < NB; b++) begin
        check($sformatf("carrier_bands[%0d]", b), carrier_bands[b], m_bands[b]);
      end
    end
    if (r) begin
      t_start = -1; m_idx = 0; m_ovr = 1'b0; m_addr = 0; chk_on = 1'b1;
      for (int b = 0; b < NB; b++) m_bands[b] = 16'sd0;
    end else if (en) begin
      if (exp_busy) begin
        m_ovr = 1'b1;
      end else begin
        t_start = n_cyc;
        f_idx   = m_idx;
`ifdef CARRIER_MUTE_EN
        f_mute  = mm;
`else
        f_mute  = '0;
`endif
      end
    end
    n_cyc++;
  endtask

  task automatic step(input logic en, input logic r, input logic [NB-1:0] mm);
    enable_44k = en;
    rst        = r;
    mute_mask  = mm;
    @(negedge clk);
    if (frame_valid === 1'b1) fv_seen++;
    model_check(en, r, mm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable_44k = 1'b0; mute_mask = '0;
    for (int b = 0; b < NB; b++) m_bands[b] = 16'sd0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b1, '0);
    repeat (5) step(1'b0, 1'b0, '0);

    // Single frame after reset
    step(1'b1, 1'b0, '0);
    repeat (FRAME_LEN + 4) step(1'b0, 1'b0, '0);
    check("t1_band14", carrier_bands[14], 16'sd3584);
    check("t1_idx", sample_idx, 32'd1);

    // Four more frames: the fifth frame reads index 0 again
    for (int f = 0; f < 4; f++) begin
      step(1'b1, 1'b0, '0);
      repeat (FRAME_LEN + $urandom_range(0, 10)) step(1'b0, 1'b0, '0);
    end
    check("t2_idx", sample_idx, 32'd1);
    check("t2_band3", carrier_bands[3], 16'sd768);

    // Overrun: second strobe at T+10 is ignored
    fv_seen = 0;
    step(1'b1, 1'b0, '0);
    repeat (9) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    repeat (FRAME_LEN) step(1'b0, 1'b0, '0);
    check("t3_fv_count", fv_seen, 32'd1);
    step(1'b1, 1'b0, '0);
    repeat (FRAME_LEN + 2) step(1'b0, 1'b0, '0);
    check("t3_overrun_sticky", overrun, 32'd1);

    // Reset in the middle of a frame
    step(1'b1, 1'b0, '0);
    repeat (7) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    fv_seen = 0;
    repeat (30) step(1'b0, 1'b0, '0);
    check("t4_no_fv", fv_seen, 32'd0);
    check("t4_addr_zero", rom_addr, 32'd0);
    step(1'b1, 1'b0, '0);
    repeat (FRAME_LEN + 2) step(1'b0, 1'b0, '0);

    // Back-to-back legal frames every 40 cycles
    step(1'b0, 1'b1, '0);
    fv_seen = 0;
    for (int f = 0; f < 8; f++) begin
      step(1'b1, 1'b0, '0);
      repeat (39) step(1'b0, 1'b0, '0);
    end
    check("t6_fv_count", fv_seen, 32'd8);
    check("t6_idx", sample_idx, 32'd0);
    check("t6_overrun", overrun, 32'd0);

`ifdef CARRIER_MUTE_EN
    // Muted bands 0 and 2: no reads, captured as zero, timing unchanged
    fv_seen = 0;
    step(1'b1, 1'b0, 15'h0005);
    repeat (FRAME_LEN + 2) step(1'b0, 1'b0, '0);
    check("t5_band0", carrier_bands[0], 16'sd0);
    check("t5_band2", carrier_bands[2], 16'sd0);
    check("t5_band1", carrier_bands[1], 16'sd256);
    check("t5_fv_count", fv_seen, 32'd1);
`endif

    // Random soak: sparse strobes, occasional reset, random mute masks
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 23) == 0), ($urandom_range(0, 499) == 0), NB'($urandom));
    end
    repeat (FRAME_LEN + 2) step(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
